// File: rtl/apb_pkg.sv
// Shared types for the CPU-to-APB bridge: FSM state encoding, bus widths
// and the captured-request record that drives the APB address/data phase.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        ACCESS   = 3'd2,
        RESP     = 3'd3,
        ERR_RESP = 3'd4
    } bridge_state_e;

    typedef struct packed {
        logic [APB_ADDR_W-1:0]   addr;
        logic                    write;
        logic [APB_DATA_W-1:0]   wdata;
        logic [APB_DATA_W/8-1:0] strb;
    } apb_req_t;

endpackage

// File: rtl/cpu_apb_bridge.sv
// CPU req/gnt/response port to APB4 master, one transfer in flight.
// Optional macro APB_TIMEOUT_EN adds an ACCESS-phase watchdog and timeout_flag.
module cpu_apb_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                pclk,
    input  logic                preset_n,
    input  logic                cpu_req,
    output logic                cpu_gnt,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic                cpu_we,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_be,
    output logic                cpu_rvalid,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_err,
    output logic [ADDR_W-1:0]   m_paddr,
    output logic                m_psel,
    output logic                m_penable,
    output logic                m_pwrite,
    output logic [DATA_W-1:0]   m_pwdata,
    output logic [DATA_W/8-1:0] m_pstrb,
    input  logic                m_pready,
    input  logic [DATA_W-1:0]   m_prdata,
    input  logic                m_pslverr
`ifdef APB_TIMEOUT_EN
    ,
    output logic                timeout_flag
`endif
);

    bridge_state_e       state_q, state_d;
    apb_req_t            req_q, req_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                tmo_hit;

    assign cpu_gnt = cpu_req && (state_q == IDLE);

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tflag_q, tflag_d;

    // Fires on the TIMEOUT_CYCLES-th consecutive not-ready ACCESS cycle.
    assign tmo_hit = (state_q == ACCESS) && !m_pready &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d   = tmo_q;
        tflag_d = tflag_q || tmo_hit;
        if (state_q == SETUP)
            tmo_d = '0;
        else if (state_q == ACCESS && !m_pready)
            tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            tmo_q   <= '0;
            tflag_q <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            tflag_q <= tflag_d;
        end
    end

    assign timeout_flag = tflag_q;
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cpu_gnt) begin
                    req_d.addr  = cpu_addr;
                    req_d.write = cpu_we;
                    req_d.wdata = cpu_wdata;
                    // A write with no lanes enabled is taken as a full-word write.
                    req_d.strb  = (cpu_we && (cpu_be == '0)) ? '1 : cpu_be;
                    if (cpu_addr[1:0] == 2'b00) begin
                        state_d = SETUP;
                    end else begin
                        state_d = ERR_RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (m_pready) begin
                    rdata_d = req_q.write ? '0 : m_prdata;
                    err_d   = m_pslverr;
                    state_d = RESP;
                end else if (tmo_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ERR_RESP;
                end
            end
            RESP:     state_d = IDLE;
            ERR_RESP: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign cpu_rvalid = (state_q == RESP) || (state_q == ERR_RESP);
    assign cpu_rdata  = rdata_q;
    assign cpu_err    = cpu_rvalid && err_q;

    assign m_psel    = (state_q == SETUP) || (state_q == ACCESS);
    assign m_penable = (state_q == ACCESS);
    assign m_paddr   = req_q.addr;
    assign m_pwrite  = req_q.write;
    assign m_pwdata  = req_q.wdata;
    assign m_pstrb   = req_q.write ? req_q.strb : '0;

endmodule
